// File: rtl/io_timer.sv
// 16-bit programmable down-counter timer on one 16-port IO bus slot.
// Prescaled ticks decrement the count; expiry latches EXP and optionally reloads.
module io_timer #(
  parameter int PRESCALE_W = 12
) (
  input  logic       busclk_i,
  input  logic       n_reset_i,
  input  logic [3:0] A_i,
  input  logic [7:0] D_i,
  output logic [7:0] D_o,
  input  logic       nWR_i,
  input  logic       nRD_i,
  output logic       interrupt_o
);

  logic [15:0]           reload_q, reload_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            snap_hi_q, snap_hi_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  en_q, en_d;
  logic                  auto_q, auto_d;
  logic                  ie_q, ie_d;
  logic [1:0]            ps_q, ps_d;
  logic                  exp_q, exp_d;
  logic                  nwr_prev_q, nwr_prev_d;
  logic                  nrd_prev_q, nrd_prev_d;

  logic                  wr_evt, rd_evt;
  logic                  wr_reload_l, wr_reload_h, wr_ctrl, wr_status;
  logic                  ctrl_stop, tick;
  logic [PRESCALE_W-1:0] mask;

  always_comb begin
    mask = '0;
    case (ps_q)
      2'd0: mask = '0;
      2'd1: mask = PRESCALE_W'(12'h00F);
      2'd2: mask = PRESCALE_W'(12'h0FF);
      2'd3: mask = PRESCALE_W'(12'hFFF);
      default: mask = '0;
    endcase
  end

  // Actions fire only on the high-to-low transition of a strobe.
  always_comb begin
    wr_evt      = !nWR_i && nwr_prev_q;
    rd_evt      = !nRD_i && nrd_prev_q;
    wr_reload_l = wr_evt && (A_i == 4'h0);
    wr_reload_h = wr_evt && (A_i == 4'h1);
    wr_ctrl     = wr_evt && (A_i == 4'h2);
    wr_status   = wr_evt && (A_i == 4'h3);
    ctrl_stop   = wr_ctrl && !D_i[0];
    tick        = en_q && ((pre_q & mask) == mask) && !wr_reload_h && !ctrl_stop;
  end

  always_comb begin
    reload_d   = reload_q;
    count_d    = count_q;
    snap_hi_d  = snap_hi_q;
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    ps_d       = ps_q;
    exp_d      = exp_q;
    nwr_prev_d = nWR_i;
    nrd_prev_d = nRD_i;
    pre_d      = en_q ? pre_q + PRESCALE_W'(1) : '0;

    if (wr_status && D_i[0]) exp_d = 1'b0;

    // Expiry set is applied after the clear so a same-cycle clear loses.
    if (tick) begin
      if (count_q != 16'h0000) begin
        count_d = count_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (auto_q) count_d = reload_q - 16'd1;
        else        en_d    = 1'b0;
      end
    end

    if (wr_reload_l) reload_d[7:0] = D_i;
    if (wr_reload_h) begin
      reload_d[15:8] = D_i;
      count_d        = {D_i, reload_q[7:0]};
      pre_d          = '0;
    end
    if (wr_ctrl) begin
      en_d   = D_i[0];
      auto_d = D_i[1];
      ie_d   = D_i[2];
      ps_d   = D_i[5:4];
    end
    if (!en_d) pre_d = '0;

    // Only the high byte of the snapshot is ever read back.
    if (rd_evt && (A_i == 4'h4)) snap_hi_d = count_q[15:8];
  end

  always_ff @(posedge busclk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      reload_q   <= 16'hFFFF;
      count_q    <= 16'hFFFF;
      snap_hi_q  <= 8'h00;
      pre_q      <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      ps_q       <= 2'd0;
      exp_q      <= 1'b0;
      nwr_prev_q <= 1'b1;
      nrd_prev_q <= 1'b1;
    end else begin
      reload_q   <= reload_d;
      count_q    <= count_d;
      snap_hi_q  <= snap_hi_d;
      pre_q      <= pre_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      ps_q       <= ps_d;
      exp_q      <= exp_d;
      nwr_prev_q <= nwr_prev_d;
      nrd_prev_q <= nrd_prev_d;
    end
  end

  always_comb begin
    D_o = 8'h00;
    case (A_i)
      4'h0: D_o = reload_q[7:0];
      4'h1: D_o = reload_q[15:8];
      4'h2: D_o = {2'b00, ps_q, 1'b0, ie_q, auto_q, en_q};
      4'h3: D_o = {6'b000000, en_q, exp_q};
      4'h4: D_o = count_q[7:0];
      4'h5: D_o = snap_hi_q;
      default: D_o = 8'h00;
    endcase
  end

  assign interrupt_o = exp_q & ie_q;

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: directed and randomized bus sequences checked against
// an arithmetic model of tick timing, count value and expiry.
module tb_io_timer;

  logic       busclk_i = 1'b0;
  logic       n_reset_i;
  logic [3:0] A_i;
  logic [7:0] D_i;
  logic [7:0] D_o;
  logic       nWR_i;
  logic       nRD_i;
  logic       interrupt_o;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr = 0;
  int last_rd = 0;
  int t_en = 0;

  io_timer #(.PRESCALE_W(12)) dut (
    .busclk_i   (busclk_i),
    .n_reset_i  (n_reset_i),
    .A_i        (A_i),
    .D_i        (D_i),
    .D_o        (D_o),
    .nWR_i      (nWR_i),
    .nRD_i      (nRD_i),
    .interrupt_o(interrupt_o)
  );

  always #5 busclk_i = ~busclk_i;
  always @(posedge busclk_i) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // A write is sampled at the posedge following the negedge where nWR_i drops.
  task automatic wr(input logic [3:0] a, input logic [7:0] d, input int hold = 1);
    @(negedge busclk_i);
    A_i = a; D_i = d; nWR_i = 1'b0;
    last_wr = cyc + 1;
    repeat (hold) @(negedge busclk_i);
    nWR_i = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d, input int hold = 1);
    @(negedge busclk_i);
    A_i = a; nRD_i = 1'b0;
    #1 d = D_o;
    last_rd = cyc + 1;
    repeat (hold) @(negedge busclk_i);
    nRD_i = 1'b1;
  endtask

  task automatic rdchk(input string tag, input logic [3:0] a, input logic [7:0] expv);
    logic [7:0] v;
    rd(a, v);
    chk(tag, 32'(v), 32'(expv));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge busclk_i);
  endtask

  task automatic wait_irq(input int budget, output int k);
    k = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge busclk_i);
      if (interrupt_o === 1'b1) begin
        k = cyc - t_en;
        break;
      end
    end
  endtask

  // Reference model: ticks come every d cycles after enable; the first expiry
  // is on tick n+1, later auto-reload expiries every n ticks.
  function automatic int model_count(input int n, input int d, input int k, input bit auto_m);
    int t;
    int u;
    t = k / d;
    if (t <= n) return n - t;
    if (!auto_m) return 0;
    u = t - (n + 1);
    return (n - 1) - (u % n);
  endfunction

  function automatic bit model_expired(input int n, input int d, input int k);
    return (k / d) >= (n + 1);
  endfunction

  task automatic start(input int n, input logic [7:0] ctrl);
    wr(4'h2, 8'h00);
    wr(4'h3, 8'h01);
    wr(4'h0, 8'(n));
    wr(4'h1, 8'(n >> 8));
    wr(4'h2, ctrl);
    t_en = last_wr;
  endtask

  task automatic trace(input int n, input int d, input bit auto_m, input bit ie, input int ncyc);
    int k;
    A_i = 4'h4;
    while (cyc - t_en < ncyc) begin
      @(negedge busclk_i);
      k = cyc - t_en;
      chk("cnt_trace", 32'(D_o), 32'(8'(model_count(n, d, k, auto_m))));
      chk("irq_trace", 32'(interrupt_o), 32'(ie & model_expired(n, d, k)));
    end
  endtask

  initial begin
    int k, n, d, ps, c;
    logic [3:0] a;
    logic [7:0] v;
    logic [15:0] snap;

    n_reset_i = 1'b0; nWR_i = 1'b1; nRD_i = 1'b1; A_i = 4'h2; D_i = 8'h00;
    repeat (3) @(negedge busclk_i);
    #1;
    chk("rst_irq", 32'(interrupt_o), 32'd0);
    chk("rst_ctrl_comb", 32'(D_o), 32'h00);
    A_i = 4'h0;
    #1 chk("rst_reload_l_comb", 32'(D_o), 32'hFF);
    @(negedge busclk_i);
    n_reset_i = 1'b1;

    rdchk("rst_ctrl", 4'h2, 8'h00);
    rdchk("rst_status", 4'h3, 8'h00);
    rdchk("rst_snap_h", 4'h5, 8'h00);
    rdchk("rst_cnt_l", 4'h4, 8'hFF);
    rdchk("rst_cnt_h", 4'h5, 8'hFF);
    rdchk("rst_reload_h", 4'h1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom_range(6, 15));
      wr(a, 8'($urandom));
      rdchk("unmapped", a, 8'h00);
    end
    rdchk("unmapped_no_side", 4'h2, 8'h00);

    // One-shot /1, reload 3.
    wr(4'h0, 8'h03);
    wr(4'h1, 8'h00);
    wr(4'h2, 8'h05);
    t_en = last_wr;
    wait_irq(50, k);
    chk("oneshot_ticks", 32'(k), 32'd4);
    rdchk("oneshot_status", 4'h3, 8'h01);
    rdchk("oneshot_ctrl", 4'h2, 8'h04);
    rdchk("oneshot_cnt", 4'h4, 8'h00);
    repeat (10) @(negedge busclk_i);
    rdchk("oneshot_cnt_hold", 4'h4, 8'h00);
    wr(4'h3, 8'h00);
    chk("status_wr0_noeffect", 32'(interrupt_o), 32'd1);
    wr(4'h3, 8'h01);
    chk("status_clear", 32'(interrupt_o), 32'd0);

    // Randomized one-shot runs across dividers.
    for (int it = 0; it < 5; it++) begin
      ps = $urandom_range(0, 2);
      n = (ps == 2) ? $urandom_range(0, 4) : $urandom_range(0, 40);
      if (it == 0) n = 0;
      d = 1 << (4 * ps);
      start(n, 8'(ps << 4) | 8'h05);
      trace(n, d, 1'b0, 1'b1, (n + 1) * d + 3);
      rdchk("rand_oneshot_status", 4'h3, 8'h01);
    end

    start(1, 8'h35);
    wait_irq(9000, k);
    chk("div4096_expiry", 32'(k), 32'(2 * 4096));

    // Auto-reload /16, reload 2.
    n = 2; d = 16;
    start(n, 8'h17);
    wait_irq(100, k);
    chk("auto_first", 32'(k), 32'((n + 1) * d));
    wr(4'h3, 8'h01);
    chk("auto_clr1", 32'(interrupt_o), 32'd0);
    wait_irq(100, k);
    chk("auto_second", 32'(k), 32'((2 * n + 1) * d));
    wr(4'h3, 8'h01);
    chk("auto_clr2", 32'(interrupt_o), 32'd0);
    wait_irq(100, k);
    chk("auto_third", 32'(k), 32'((3 * n + 1) * d));

    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(1, 6);
      ps = $urandom_range(0, 1);
      d = 1 << (4 * ps);
      start(n, 8'(ps << 4) | 8'h07);
      trace(n, d, 1'b1, 1'b1, (3 * n + 2) * d);
    end

    // Held write strobe and reload-vs-tick collision at /1.
    start(200, 8'h01);
    repeat (10) @(negedge busclk_i);
    wr(4'h0, 8'h50);
    wr(4'h1, 8'h00, 5);
    c = last_wr;
    A_i = 4'h4;
    #1 chk("held_wr_single_commit", 32'(D_o), 32'(8'(16'h0050 - (cyc - c))));
    wr(4'h1, 8'h00);
    A_i = 4'h4;
    #1 chk("reload_tick_collision_div1", 32'(D_o), 32'(8'(16'h0050 - (cyc - last_wr))));

    // Held read strobe: one snapshot, high byte coherent with low byte.
    wr(4'h0, 8'h03);
    wr(4'h1, 8'h01);
    c = last_wr;
    rd(4'h4, v, 5);
    snap = 16'h0103 - 16'(last_rd - 1 - c);
    chk("held_rd_cnt_l", 32'(v), 32'(snap[7:0]));
    rdchk("held_rd_cnt_h", 4'h5, snap[15:8]);
    rd(4'h4, v);
    chk("held_rd_live_moved", 32'(v), 32'(8'(16'h0103 - 16'(last_rd - 1 - c))));

    // RELOAD_H write landing on a /16 tick.
    start(10, 8'h11);
    wr(4'h0, 8'h20);
    wait_cyc(t_en + 14);
    wr(4'h1, 8'h00);
    A_i = 4'h4;
    #1 chk("reload_tick_collision_div16", 32'(D_o), 32'h20);
    t_en = last_wr;
    trace(16'h20, 16, 1'b0, 1'b0, 40);

    // CTRL EN=0 write landing on the expiry tick.
    start(2, 8'h05);
    wait_cyc(t_en + 1);
    wr(4'h2, 8'h04);
    chk("ctrl_stop_collision_irq", 32'(interrupt_o), 32'd0);
    rdchk("ctrl_stop_collision_status", 4'h3, 8'h00);
    rdchk("ctrl_stop_collision_cnt", 4'h4, 8'h00);

    // STATUS clear landing on the expiry tick.
    start(5, 8'h05);
    wait_cyc(t_en + 4);
    wr(4'h3, 8'h01);
    chk("clear_expiry_collision_irq", 32'(interrupt_o), 32'd1);
    rdchk("clear_expiry_collision_status", 4'h3, 8'h01);

    // Masking with IE=0.
    n = $urandom_range(1, 20);
    start(n, 8'h01);
    trace(n, 1, 1'b0, 1'b0, n + 4);
    rdchk("mask_status", 4'h3, 8'h01);
    wr(4'h2, 8'h04);
    chk("mask_ie_set", 32'(interrupt_o), 32'd1);
    wr(4'h2, 8'h00);
    chk("mask_ie_clr", 32'(interrupt_o), 32'd0);
    rdchk("mask_exp_kept", 4'h3, 8'h01);

    // Reset while counting with EXP and IE set.
    start(3, 8'h07);
    wait_irq(20, k);
    chk("pre_reset_expiry", 32'(k), 32'd4);
    #2 n_reset_i = 1'b0;
    #1 chk("async_reset_irq", 32'(interrupt_o), 32'd0);
    A_i = 4'h2;
    #1 chk("async_reset_ctrl", 32'(D_o), 32'h00);
    repeat (2) @(negedge busclk_i);
    n_reset_i = 1'b1;
    rdchk("post_reset_ctrl", 4'h2, 8'h00);
    rdchk("post_reset_status", 4'h3, 8'h00);
    rdchk("post_reset_cnt_l", 4'h4, 8'hFF);
    rdchk("post_reset_cnt_h", 4'h5, 8'hFF);
    repeat (20) @(negedge busclk_i);
    rdchk("post_reset_idle", 4'h4, 8'hFF);
    chk("post_reset_irq", 32'(interrupt_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
